pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register for the pipelined CPU. It replaces the fixed-field, always-enabled inter-stage DFF banks (IF/ID, ID/EX, ...). It carries a datapath payload and a control-signal vector between stages, using valid/ready handshaking with a two-entry skid buffer. It adds stall (backpressure), flush (bubble insertion) with control zeroing, and saturating stall/flush event counters for performance debug.

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry with valid/ready handshake,
// flush-to-bubble and saturating stall/flush event counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state: main_ctrl is kept zero whenever main is not valid, so out_ctrl needs no gate
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end else begin
                            state_d     = ST_EMPTY;
                            main_ctrl_d = '0;
                        end
                    end else if (in_valid) begin
                        state_d     = ST_SKID;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_SKID);
        out_valid_d = (state_d != ST_EMPTY);

        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 to reach saturation quickly).
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD;
        in_ctrl   = 16'h1234;
        out_ready = 1'b1;
        flush     = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,        64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);

        // Streaming at full rate
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            in_ctrl  = 16'(i);
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data",  out_data,        64'(i));
            check("stream_ctrl",  64'(out_ctrl),  64'(i));
            check("stream_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_ctrl",  64'(out_ctrl),  64'd0);
        check("stream_stall_cnt",   64'(stall_cnt), 64'd0);

        // Backpressure into skid entry
        in_valid = 1'b1; in_data = 64'h10; in_ctrl = 16'h0001; out_ready = 1'b1;
        step();
        check("bp_a_data", out_data, 64'h10);
        in_data = 64'h20; in_ctrl = 16'h0002; out_ready = 1'b0;
        step();
        check("bp_skid_ready", 64'(in_ready),  64'd0);
        check("bp_skid_data",  out_data,        64'h10);
        check("bp_stall_1",    64'(stall_cnt), 64'd1);
        in_valid = 1'b0;
        step();
        step();
        check("bp_hold_data",  out_data,        64'h10);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_stall_3",    64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        step();
        check("bp_b_data",  out_data,       64'h20);
        check("bp_b_ctrl",  64'(out_ctrl), 64'h2);
        check("bp_b_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_stall_keep",  64'(stall_cnt), 64'd3);

        // Flush while both entries are valid
        in_valid = 1'b1; in_data = 64'h40; in_ctrl = 16'hFFFF; out_ready = 1'b0;
        step();
        in_data = 64'h41;
        step();
        check("fl_skid_ready", 64'(in_ready), 64'd0);
        check("fl_skid_ctrl",  64'(out_ctrl), 64'hFFFF);
        check("fl_stall_4",    64'(stall_cnt), 64'd4);
        flush = 1'b1; in_data = 64'h30;
        step();
        check("fl_valid",     64'(out_valid), 64'd0);
        check("fl_ctrl",      64'(out_ctrl),  64'd0);
        check("fl_ready",     64'(in_ready),  64'd1);
        check("fl_cnt_1",     64'(flush_cnt), 64'd1);
        check("fl_stall_hold", 64'(stall_cnt), 64'd4);
        step();
        check("fl_empty_cnt",   64'(flush_cnt), 64'd1);
        check("fl_empty_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_emerge", 64'(out_valid), 64'd0);
        end

        // Stall counter saturation
        in_valid = 1'b1; in_data = 64'h50; in_ctrl = 16'h0050; out_ready = 1'b0;
        step();
        check("sat_start", 64'(stall_cnt), 64'd4);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_15",   64'(stall_cnt), 64'd15);
        check("sat_data", out_data,        64'h50);
        step();
        check("sat_hold", 64'(stall_cnt), 64'd15);

        // Reset while in SKID
        in_valid = 1'b1; in_data = 64'h60; in_ctrl = 16'h0060;
        step();
        check("rs_skid_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; reset = 1'b1; flush = 1'b1;
        step();
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_data",  out_data,        64'd0);
        check("rs_ctrl",  64'(out_ctrl),  64'd0);
        check("rs_ready", 64'(in_ready),  64'd1);
        check("rs_stall", 64'(stall_cnt), 64'd0);
        check("rs_flush", 64'(flush_cnt), 64'd0);
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rs_no_stale", 64'(out_valid), 64'd0);
        end

        // Normal operation after reset
        in_valid = 1'b1; in_data = 64'h70; in_ctrl = 16'h0070;
        step();
        check("post_data", out_data,       64'h70);
        check("post_ctrl", 64'(out_ctrl), 64'h70);
        in_valid = 1'b0;
        step();
        check("post_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
